// File: rtl/conv_window_sched_if.sv
`timescale 1ns/1ps
// conv_window_sched_if
//   Tap stream from the window scan controller to the 3x3 convolution stage.
//   master: drives the tap fields, out_valid and mem_rd_en, samples out_ready.
//   slave : samples the tap fields, drives out_ready.
//   Signals: out_valid/out_ready handshake, out_zero (padding tap),
//            mem_addr (feature-map address), mem_rd_en (BRAM read strobe),
//            tap_k/win_i/win_j (window position), row_last, frame_last.
interface conv_window_sched_if #(
    parameter int ADDR_W = 13
);
    logic              out_valid;
    logic              out_ready;
    logic              out_zero;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [1:0]        tap_k;
    logic [7:0]        win_i;
    logic [7:0]        win_j;
    logic              row_last;
    logic              frame_last;

    modport master (
        output out_valid, out_zero, mem_addr, mem_rd_en,
               tap_k, win_i, win_j, row_last, frame_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_zero, mem_addr, mem_rd_en,
               tap_k, win_i, win_j, row_last, frame_last,
        output out_ready
    );
endinterface

// File: rtl/conv_window_sched.sv
`timescale 1ns/1ps
// conv_window_sched
//   Walks a zero-padded IMG_W x IMG_H feature map in 3-row window order
//   (win_j outer, win_i middle, tap_k inner) and emits one tap per handshake,
//   each carrying a BRAM address or a zero-fill flag.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a frame (sampled only in IDLE)
//   cfg_pad_x/y     padding per side, latched on accepted start
//   abort           synchronous cancel of a running scan (beats handshake)
//   busy            high while scanning
//   done            one-cycle pulse after the final tap is accepted
//   tap_bus         tap stream (master side)
module conv_window_sched #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [3:0]                  cfg_pad_x,
    input  logic [3:0]                  cfg_pad_y,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    conv_window_sched_if.master         tap_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [10:0] IMG_W_S = 11'(IMG_W);
    localparam logic signed [10:0] IMG_H_S = 11'(IMG_H);

    state_t      state, state_n;
    logic [3:0]  pad_x_q, pad_y_q;
    logic [1:0]  tap_k_q, tap_k_n;
    logic [7:0]  win_i_q, win_i_n;
    logic [7:0]  win_j_q, win_j_n;
    logic        latch_cfg;

    logic [8:0]  pw, ph;
    logic        in_scan, hs;
    logic        k_last, i_last, j_last;
    logic signed [10:0] pos_x, pos_y;
    logic        in_img;
    logic [ADDR_W-1:0] lin_addr;

    // Padded geometry derived from the latched pads, so cfg changes mid-scan
    // cannot disturb the walk.
    assign pw = 9'(IMG_W) + {4'b0, pad_x_q, 1'b0};
    assign ph = 9'(IMG_H) + {4'b0, pad_y_q, 1'b0};

    assign in_scan = (state == SCAN);
    assign hs      = in_scan & tap_bus.out_ready;

    assign k_last = (tap_k_q == 2'd2);
    assign i_last = ({1'b0, win_i_q} == pw - 9'd1);
    assign j_last = ({1'b0, win_j_q} == ph - 9'd3);

    // Position in the unpadded image; negative means left/top padding.
    assign pos_x = $signed({3'b000, win_i_q}) - $signed({7'b0, pad_x_q});
    assign pos_y = $signed({3'b000, win_j_q}) + $signed({9'b0, tap_k_q})
                 - $signed({7'b0, pad_y_q});

    assign in_img = (pos_x >= 11'sd0) && (pos_x < IMG_W_S) &&
                    (pos_y >= 11'sd0) && (pos_y < IMG_H_S);

    assign lin_addr = ADDR_W'(pos_y[9:0]) * ADDR_W'(IMG_W) + ADDR_W'(pos_x[9:0]);

    // Tap fields are decoded from registered state/counters only; gating with
    // in_scan keeps them at their reset values outside a scan.
    assign tap_bus.out_valid  = in_scan;
    assign tap_bus.out_zero   = in_scan & ~in_img;
    assign tap_bus.mem_addr   = (in_scan & in_img) ? lin_addr : '0;
    assign tap_bus.tap_k      = tap_k_q;
    assign tap_bus.win_i      = win_i_q;
    assign tap_bus.win_j      = win_j_q;
    assign tap_bus.row_last   = in_scan & k_last & i_last;
    assign tap_bus.frame_last = in_scan & k_last & i_last & j_last;
    assign tap_bus.mem_rd_en  = tap_bus.out_valid & tap_bus.out_ready & ~tap_bus.out_zero;

    assign busy = in_scan;
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tap_k_q <= '0;
            win_i_q <= '0;
            win_j_q <= '0;
        end else begin
            state   <= state_n;
            tap_k_q <= tap_k_n;
            win_i_q <= win_i_n;
            win_j_q <= win_j_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_x_q <= '0;
            pad_y_q <= '0;
        end else if (latch_cfg) begin
            pad_x_q <= cfg_pad_x;
            pad_y_q <= cfg_pad_y;
        end
    end

    always_comb begin
        state_n   = state;
        tap_k_n   = tap_k_q;
        win_i_n   = win_i_q;
        win_j_n   = win_j_q;
        latch_cfg = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SCAN;
                    latch_cfg = 1'b1;
                    tap_k_n   = '0;
                    win_i_n   = '0;
                    win_j_n   = '0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_n = IDLE;
                    tap_k_n = '0;
                    win_i_n = '0;
                    win_j_n = '0;
                end else if (hs) begin
                    // All three counters wrap to 0 on the frame's last tap,
                    // leaving them at their idle values for DONE/IDLE.
                    if (k_last) begin
                        tap_k_n = '0;
                        if (i_last) begin
                            win_i_n = '0;
                            if (j_last) begin
                                win_j_n = '0;
                                state_n = DONE;
                            end else begin
                                win_j_n = win_j_q + 8'd1;
                            end
                        end else begin
                            win_i_n = win_i_q + 8'd1;
                        end
                    end else begin
                        tap_k_n = tap_k_q + 2'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_window_sched.sv
`timescale 1ns/1ps
// tb_conv_window_sched
//   Scoreboard bench: on each start the full expected tap sequence is queued
//   from a reference model; every accepted tap is popped and compared.
module tb_conv_window_sched;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] cfg_pad_x;
    logic [3:0] cfg_pad_y;
    logic       busy;
    logic       done;

    conv_window_sched_if #(.ADDR_W(ADDR_W)) bus ();

    conv_window_sched #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_pad_x(cfg_pad_x),
        .cfg_pad_y(cfg_pad_y),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .tap_bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              zero;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        k;
        logic [7:0]        i;
        logic [7:0]        j;
        logic              rl;
        logic              fl;
    } tap_t;

    tap_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    bit   stall_mode = 1'b0;
    tap_t last_tap;
    tap_t held;
    bit   held_v = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the scan order and padding rules.
    task automatic load_frame(input int px, input int py);
        int pw = IMG_W + 2 * px;
        int ph = IMG_H + 2 * py;
        for (int j = 0; j <= ph - 3; j++) begin
            for (int i = 0; i < pw; i++) begin
                for (int k = 0; k < 3; k++) begin
                    int   x;
                    int   y;
                    tap_t t;
                    x = i - px;
                    y = j + k - py;
                    t.zero = (x < 0) || (x >= IMG_W) || (y < 0) || (y >= IMG_H);
                    t.addr = t.zero ? '0 : ADDR_W'(y * IMG_W + x);
                    t.k    = 2'(k);
                    t.i    = 8'(i);
                    t.j    = 8'(j);
                    t.rl   = (i == pw - 1) && (k == 2);
                    t.fl   = t.rl && (j == ph - 3);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        tap_t got;
        got = {bus.out_zero, bus.mem_addr, bus.tap_k, bus.win_i, bus.win_j,
               bus.row_last, bus.frame_last};
        if (done) done_cnt++;
        if (held_v && bus.out_valid) chk("stall_hold", 64'(got), 64'(held));
        held_v = bus.out_valid && !bus.out_ready;
        held   = got;
        if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                tap_t e;
                e = exp_q.pop_front();
                chk("tap", 64'(got), 64'(e));
                chk("rd_en", 64'(bus.mem_rd_en), 64'(!e.zero));
                last_tap = got;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.out_ready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    endtask

    task automatic start_frame(input int px, input int py);
        exp_q.delete();
        load_frame(px, py);
        hs_cnt   = 0;
        done_cnt = 0;
        cfg_pad_x = 4'(px);
        cfg_pad_y = 4'(py);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy_valid", 64'({busy, bus.out_valid}), 64'd3);
        chk("start_pos", 64'({bus.tap_k, bus.win_i, bus.win_j}), 64'd0);
    endtask

    task automatic finish_frame(input int exp_taps, input int budget, input bit chk_cycles);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_state", 64'({busy, bus.out_valid}), 64'd0);
        chk("tap_count", 64'(hs_cnt), 64'(exp_taps));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        if (chk_cycles) chk("frame_cycles", 64'(n), 64'(exp_taps));
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_pad_x = '0;
        cfg_pad_y = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy, done, bus.out_valid, bus.out_zero, bus.mem_addr,
                                bus.tap_k, bus.win_i, bus.win_j, bus.row_last,
                                bus.frame_last, bus.mem_rd_en}), 64'd0);
        #2 rst = 1'b0;
        step();

        // No padding, full throughput.
        start_frame(0, 0);
        finish_frame(11904, 20000, 1'b1);
        chk("last_addr", 64'(last_tap.addr), 64'd4095);
        chk("last_frame_last", 64'(last_tap.fl), 64'd1);

        // One pixel of padding on every side.
        start_frame(1, 1);
        finish_frame(12672, 20000, 1'b1);

        // Random stalls plus an ignored start carrying a different pad.
        stall_mode = 1'b1;
        start_frame(1, 1);
        n = 0;
        while (hs_cnt < 1000 && n < 5000) begin
            step();
            n++;
        end
        cfg_pad_x = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_busy", 64'(busy), 64'd1);
        finish_frame(12672, 40000, 1'b0);
        stall_mode = 1'b0;

        // Abort on tap 500 with out_ready high.
        start_frame(1, 1);
        n = 0;
        while (hs_cnt < 499 && n < 2000) begin
            step();
            n++;
        end
        chk("abort_reach", 64'(hs_cnt), 64'd499);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 64'({busy, bus.out_valid, done}), 64'd0);
        chk("abort_pos", 64'({bus.tap_k, bus.win_i, bus.win_j}), 64'd0);
        exp_q.delete();
        repeat (5) step();
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // Restart after abort begins from (0,0,0); scoreboard checks the taps.
        start_frame(1, 1);
        repeat (30) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        repeat (2) step();

        // Asynchronous reset between clock edges mid-scan.
        start_frame(0, 0);
        repeat (300) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 64'({busy, done, bus.out_valid, bus.out_zero, bus.mem_addr,
                                    bus.tap_k, bus.win_i, bus.win_j, bus.row_last,
                                    bus.frame_last, bus.mem_rd_en}), 64'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        start_frame(0, 0);
        finish_frame(11904, 20000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
